// File: rtl/pattern_scheduler.sv
// Shares one pattern command list between note lanes: round-robin grant of lane
// requests, fetch from a synchronous ROM, one-hot issue, plus a saturating score.
module pattern_scheduler #(
   parameter int N_LANES = 4,
   parameter int CMD_W   = 4,
   parameter int IDX_W   = 6,
   parameter int SCORE_W = 8
) (
   input  logic               CLOCK_25,
   input  logic               rst_n,
   input  logic [N_LANES-1:0] req,
   input  logic [N_LANES-1:0] hit,
   input  logic [IDX_W-1:0]   list_end,
   output logic [IDX_W-1:0]   rom_addr,
   input  logic [CMD_W-1:0]   rom_data,
   output logic [CMD_W-1:0]   cmd_out,
   output logic [N_LANES-1:0] cmd_valid,
   output logic               busy,
   output logic               game_over,
   output logic [SCORE_W-1:0] score
);

   localparam int LG_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int POP_W = $clog2(N_LANES + 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

   state_t             r_state;
   logic [N_LANES-1:0] r_req_q;
   logic [N_LANES-1:0] r_hit_q;
   logic [N_LANES-1:0] r_hit_edge;
   logic [N_LANES-1:0] r_pending;
   logic [N_LANES-1:0] r_grant;
   logic [N_LANES-1:0] r_cmd_valid;
   logic [LG_W-1:0]    r_last_grant;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_rom_addr;
   logic [CMD_W-1:0]   r_cmd_out;
   logic               r_busy;
   logic               r_game_over;
   logic [SCORE_W-1:0] r_score;

   logic [N_LANES-1:0] w_req_edge;
   logic [N_LANES-1:0] w_hit_edge;
   logic [N_LANES-1:0] w_arb_onehot;
   logic [LG_W-1:0]    w_arb_idx;
   logic [LG_W-1:0]    w_lane;
   logic               w_arb_found;
   logic [IDX_W-1:0]   w_idx_next;
   logic [POP_W-1:0]   w_pop;
   logic [SCORE_W:0]   w_sum;

   assign w_req_edge = req & ~r_req_q;
   assign w_hit_edge = hit & ~r_hit_q;
   assign w_idx_next = r_idx + IDX_W'(1);
   assign w_sum      = {1'b0, r_score} + (SCORE_W + 1)'(w_pop);

   // Round-robin: search begins one lane past the last grant.
   always_comb begin
      w_arb_onehot = '0;
      w_arb_idx    = '0;
      w_lane       = '0;
      w_arb_found  = 1'b0;
      for (int k = 1; k <= N_LANES; k++) begin
         w_lane = LG_W'((int'(r_last_grant) + k) % N_LANES);
         if (!w_arb_found && r_pending[w_lane]) begin
            w_arb_found          = 1'b1;
            w_arb_onehot[w_lane] = 1'b1;
            w_arb_idx            = w_lane;
         end
      end
   end

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < N_LANES; k++) begin
         w_pop = w_pop + POP_W'(r_hit_edge[k]);
      end
   end

   // cmd_valid is a one-cycle strobe with no ready: the granted lane must take
   // cmd_out in the cycle cmd_valid is high. Both are loaded on entry to ISSUE
   // so the strobe is visible during the ISSUE cycle itself.
   always_ff @(posedge CLOCK_25 or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_req_q      <= '0;
         r_pending    <= '0;
         r_grant      <= '0;
         r_cmd_valid  <= '0;
         r_last_grant <= LG_W'(N_LANES - 1);
         r_idx        <= '0;
         r_rom_addr   <= '0;
         r_cmd_out    <= '0;
         r_busy       <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_req_q     <= req;
         r_pending   <= r_pending | w_req_edge;
         r_cmd_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (r_idx == list_end) begin
                  r_state     <= S_DONE;
                  r_game_over <= 1'b1;
                  r_pending   <= '0;
               end else if (|r_pending) begin
                  r_grant      <= w_arb_onehot;
                  r_last_grant <= w_arb_idx;
                  r_rom_addr   <= r_idx;
                  r_busy       <= 1'b1;
                  r_state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_cmd_out   <= rom_data;
               r_cmd_valid <= r_grant;
               r_state     <= S_ISSUE;
            end
            S_ISSUE: begin
               r_idx     <= w_idx_next;
               r_busy    <= 1'b0;
               // A fresh edge on the granted lane outranks the clear.
               r_pending <= (r_pending & ~r_grant) | w_req_edge;
               if (w_idx_next == list_end) begin
                  r_state     <= S_DONE;
                  r_game_over <= 1'b1;
                  r_pending   <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_DONE: begin
               r_pending   <= '0;
               r_game_over <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Hit edges are registered before the adder; score freezes at game over.
   always_ff @(posedge CLOCK_25 or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_q    <= '0;
         r_hit_edge <= '0;
         r_score    <= '0;
      end else begin
         r_hit_q    <= hit;
         r_hit_edge <= w_hit_edge;
         if (!r_game_over) begin
            r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
         end
      end
   end

   assign rom_addr  = r_rom_addr;
   assign cmd_out   = r_cmd_out;
   assign cmd_valid = r_cmd_valid;
   assign busy      = r_busy;
   assign game_over = r_game_over;
   assign score     = r_score;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler: expected issues go into a queue that a
// negedge monitor drains; timing, score and reset behaviour are checked inline.
module tb_pattern_scheduler;

   localparam int N_LANES = 4;
   localparam int CMD_W   = 4;
   localparam int IDX_W   = 6;
   localparam int SCORE_W = 8;
   localparam int W       = N_LANES + CMD_W;

   logic               CLOCK_25;
   logic               rst_n;
   logic [N_LANES-1:0] req;
   logic [N_LANES-1:0] hit;
   logic [IDX_W-1:0]   list_end;
   logic [IDX_W-1:0]   rom_addr;
   logic [CMD_W-1:0]   rom_data;
   logic [CMD_W-1:0]   cmd_out;
   logic [N_LANES-1:0] cmd_valid;
   logic               busy;
   logic               game_over;
   logic [SCORE_W-1:0] score;

   logic [CMD_W-1:0] rom_mem [0:7];
   logic [W-1:0]     exp_q[$];
   logic [W-1:0]     exp_item;
   int               n_checks;
   int               n_fail;
   int               exp_score;

   pattern_scheduler #(
      .N_LANES(N_LANES), .CMD_W(CMD_W), .IDX_W(IDX_W), .SCORE_W(SCORE_W)
   ) dut (
      .CLOCK_25 (CLOCK_25),
      .rst_n    (rst_n),
      .req      (req),
      .hit      (hit),
      .list_end (list_end),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .cmd_out  (cmd_out),
      .cmd_valid(cmd_valid),
      .busy     (busy),
      .game_over(game_over),
      .score    (score)
   );

   // ---------------- clock / reset ----------------
   initial CLOCK_25 = 1'b0;
   always #20 CLOCK_25 = ~CLOCK_25;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Synchronous ROM model: data for a new address is ready before the next rising edge.
   initial begin
      rom_mem[0] = 4'd5;  rom_mem[1] = 4'd9;  rom_mem[2] = 4'd2;  rom_mem[3] = 4'd7;
      rom_mem[4] = 4'd12; rom_mem[5] = 4'd3;  rom_mem[6] = 4'd1;  rom_mem[7] = 4'd14;
   end
   always @(negedge CLOCK_25) rom_data <= rom_mem[rom_addr[2:0]];

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLOCK_25) begin
      if (rst_n && cmd_valid != '0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_cmd: got valid=%b cmd=%0d expected no issue at %0t",
                     cmd_valid, cmd_out, $time);
         end else begin
            exp_item = exp_q.pop_front();
            check("cmd_issue", 32'({cmd_valid, cmd_out}), 32'(exp_item));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic [IDX_W-1:0] le);
      rst_n    = 1'b0;
      req      = '0;
      hit      = '0;
      list_end = le;
      #1;
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_out",   32'(cmd_out),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_game_over", 32'(game_over), 32'd0);
      check("rst_score",     32'(score),     32'd0);
      check("rst_rom_addr",  32'(rom_addr),  32'd0);
      repeat (2) @(negedge CLOCK_25);
      rst_n = 1'b1;
   endtask

   task automatic pulse_hit(input logic [N_LANES-1:0] pat);
      @(negedge CLOCK_25);
      hit = pat;
      @(negedge CLOCK_25);
      hit = '0;
      exp_score = exp_score + $countones(pat);
      if (exp_score > 255) exp_score = 255;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [N_LANES-1:0] ev;
      n_checks  = 0;
      n_fail    = 0;
      exp_score = 0;
      rst_n     = 1'b0;
      req       = '0;
      hit       = '0;
      list_end  = 6'd3;

      // Single request on lane 2
      do_reset(6'd3);
      repeat (2) @(negedge CLOCK_25);
      req = 4'b0100;
      exp_q.push_back({4'b0100, 4'd5});
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLOCK_25);
         ev = (c == 3) ? 4'b0100 : 4'b0000;
         check("single_valid", 32'(cmd_valid), 32'(ev));
         check("single_busy", 32'(busy), 32'((c == 2) || (c == 3)));
         if (c == 2) check("single_rom_addr", 32'(rom_addr), 32'd0);
         if (c >= 3) check("single_cmd_out", 32'(cmd_out), 32'd5);
         if (c == 1) req = '0;
      end

      // Round-robin over lanes 0, 1, 3 from one simultaneous request
      do_reset(6'd3);
      @(negedge CLOCK_25);
      req = 4'b1011;
      exp_q.push_back({4'b0001, 4'd5});
      exp_q.push_back({4'b0010, 4'd9});
      exp_q.push_back({4'b1000, 4'd2});
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLOCK_25);
         ev = '0;
         if (c == 3) ev = 4'b0001;
         if (c == 6) ev = 4'b0010;
         if (c == 9) ev = 4'b1000;
         check("rr_valid", 32'(cmd_valid), 32'(ev));
         check("rr_game_over", 32'(game_over), 32'(c >= 10));
         if (c == 5) check("rr_rom_addr1", 32'(rom_addr), 32'd1);
         if (c == 8) check("rr_rom_addr2", 32'(rom_addr), 32'd2);
         if (c == 1) req = '0;
      end

      // Exhausted list: requests ignored, score frozen
      @(negedge CLOCK_25);
      req = 4'b0010;
      @(negedge CLOCK_25);
      req = '0;
      pulse_hit(4'b1111);
      exp_score = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLOCK_25);
         check("exh_valid", 32'(cmd_valid), 32'd0);
         check("exh_game_over", 32'(game_over), 32'd1);
      end
      check("exh_score_frozen", 32'(score), 32'(exp_score));

      // Empty list: game over straight out of reset
      do_reset(6'd0);
      check("empty_go_before", 32'(game_over), 32'd0);
      @(negedge CLOCK_25);
      check("empty_go_after", 32'(game_over), 32'd1);
      req = 4'b0001;
      for (int c = 1; c <= 5; c++) begin
         @(negedge CLOCK_25);
         if (c == 1) req = '0;
         check("empty_valid", 32'(cmd_valid), 32'd0);
      end

      // Re-request on lane 0 during its own ISSUE cycle
      do_reset(6'd5);
      @(negedge CLOCK_25);
      req = 4'b0001;
      exp_q.push_back({4'b0001, 4'd5});
      exp_q.push_back({4'b0001, 4'd9});
      for (int c = 1; c <= 7; c++) begin
         @(negedge CLOCK_25);
         ev = ((c == 3) || (c == 6)) ? 4'b0001 : 4'b0000;
         check("rereq_valid", 32'(cmd_valid), 32'(ev));
         if (c == 1) req = '0;
         if (c == 3) req = 4'b0001;
         if (c == 4) req = '0;
      end

      // Repeated edge while already pending yields a single grant
      @(negedge CLOCK_25);
      req = 4'b0010;
      exp_q.push_back({4'b0010, 4'd2});
      for (int c = 1; c <= 9; c++) begin
         @(negedge CLOCK_25);
         ev = (c == 3) ? 4'b0010 : 4'b0000;
         check("repeat_valid", 32'(cmd_valid), 32'(ev));
         if (c == 1) req = '0;
         if (c == 2) req = 4'b0010;
         if (c == 3) req = '0;
      end

      // Score: three simultaneous hits land two cycles later
      do_reset(6'd3);
      exp_score = 0;
      @(negedge CLOCK_25);
      hit = 4'b1101;
      exp_score = 3;
      @(negedge CLOCK_25);
      check("score_lag1", 32'(score), 32'd0);
      hit = '0;
      @(negedge CLOCK_25);
      check("score_plus3", 32'(score), 32'(exp_score));

      // Score saturation
      for (int p = 0; p < 62; p++) pulse_hit(4'b1111);
      pulse_hit(4'b0111);
      repeat (3) @(negedge CLOCK_25);
      check("score_254", 32'(score), 32'(exp_score));
      pulse_hit(4'b0011);
      repeat (3) @(negedge CLOCK_25);
      check("score_sat", 32'(score), 32'(exp_score));
      pulse_hit(4'b1111);
      repeat (3) @(negedge CLOCK_25);
      check("score_sat_hold", 32'(score), 32'(exp_score));

      // Async reset during FETCH drops the grant; lane 0 regains priority
      do_reset(6'd3);
      @(negedge CLOCK_25);
      req = 4'b0100;
      @(negedge CLOCK_25);
      req = '0;
      @(negedge CLOCK_25);
      check("arst_in_fetch", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(cmd_valid), 32'd0);
      check("arst_rom_addr", 32'(rom_addr), 32'd0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge CLOCK_25);
         check("arst_hold_valid", 32'(cmd_valid), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge CLOCK_25);
      req = 4'b1001;
      exp_q.push_back({4'b0001, 4'd5});
      exp_q.push_back({4'b1000, 4'd9});
      for (int c = 1; c <= 7; c++) begin
         @(negedge CLOCK_25);
         ev = '0;
         if (c == 3) ev = 4'b0001;
         if (c == 6) ev = 4'b1000;
         check("arst_prio_valid", 32'(cmd_valid), 32'(ev));
         if (c == 1) req = '0;
      end

      // ---------------- final report ----------------
      repeat (2) @(negedge CLOCK_25);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
